// File: rtl/noise_qualifier_pkg.sv
// Shared types and constants for the noise_qualifier block: FSM state, edge-count width and counter sizing.
package noise_qualifier_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int EDGE_CNT_W = 8;
    localparam logic [EDGE_CNT_W-1:0] EDGE_CNT_MAX = 8'd255;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noise_qualifier_debounce_filter.sv
// Synchroniser plus stability-counter debounce for the comparator input.
// Compiled only when NOISE_QUALIFIER_DEBOUNCE_EN is defined.
`ifdef NOISE_QUALIFIER_DEBOUNCE_EN
module debounce_filter
    import noise_qualifier_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level
);

    localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign o_level    = r_level;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    // The level flips on the Nth consecutive disagreeing cycle; one agreeing cycle restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync_out != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= w_sync_out;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule
`endif

// File: rtl/noise_qualifier.sv
// Window-qualified noise detector: counts debounced rising edges of comp_in per measurement window.
// Define NOISE_QUALIFIER_DEBOUNCE_EN to insert the debounce filter after the synchroniser.
module noise_qualifier
    import noise_qualifier_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WINDOW_CYCLES   = 50000,
    parameter int MIN_EDGES       = 4
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  comp_in,
    output logic                  noise_valid,
    output logic [EDGE_CNT_W-1:0] edge_count,
    output logic                  window_done,
    output logic                  busy
);

    localparam int WIN_W = cnt_w(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [EDGE_CNT_W-1:0] MIN_CNT  = EDGE_CNT_W'(MIN_EDGES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (WINDOW_CYCLES < 1) begin : g_bad_window
        $error("WINDOW_CYCLES must be at least 1");
    end
    if (MIN_EDGES < 1 || MIN_EDGES > 255) begin : g_bad_min
        $error("MIN_EDGES must be 1..255");
    end

    function automatic logic [EDGE_CNT_W-1:0] sat_inc(input logic [EDGE_CNT_W-1:0] cnt,
                                                      input logic                  inc);
        if (inc && (cnt != EDGE_CNT_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    logic                  w_deb;
    logic                  w_rise;
    logic [EDGE_CNT_W-1:0] w_run_next;
    logic                  r_deb_prev;
    state_t                r_state;
    logic [WIN_W-1:0]      r_win;
    logic [EDGE_CNT_W-1:0] r_run;
    logic                  r_noise_valid;
    logic [EDGE_CNT_W-1:0] r_edge_count;
    logic                  r_window_done;
    logic                  r_busy;

`ifdef NOISE_QUALIFIER_DEBOUNCE_EN
    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_async (comp_in),
        .o_level (w_deb)
    );
`else
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], comp_in};
        end
    end

    assign w_deb = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_deb_prev <= 1'b0;
        end else begin
            r_deb_prev <= w_deb;
        end
    end

    // An edge seen on the final window cycle still lands in that window's verdict.
    assign w_rise     = w_deb & ~r_deb_prev;
    assign w_run_next = sat_inc(r_run, w_rise);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_win         <= '0;
            r_run         <= '0;
            r_noise_valid <= 1'b0;
            r_edge_count  <= '0;
            r_window_done <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_win <= '0;
                    r_run <= '0;
                    if (enable) begin
                        r_state <= COUNT;
                        r_busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (r_win == WIN_LAST) begin
                        r_edge_count  <= w_run_next;
                        r_noise_valid <= (w_run_next >= MIN_CNT);
                        r_window_done <= 1'b1;
                        r_win         <= '0;
                        r_run         <= '0;
                        if (!enable) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (!enable) begin
                        // Aborted window: the verdict is withdrawn, the last count is kept.
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_noise_valid <= 1'b0;
                        r_win         <= '0;
                        r_run         <= '0;
                    end else begin
                        r_win <= r_win + 1'b1;
                        r_run <= w_run_next;
                    end
                end
            endcase
        end
    end

    assign noise_valid = r_noise_valid;
    assign edge_count  = r_edge_count;
    assign window_done = r_window_done;
    assign busy        = r_busy;

endmodule

// File: doc/noise_qualifier.md
# noise_qualifier

Upstream stage of the diode controller. Turns the raw, asynchronous photodetector comparator output into the clean, window-qualified `noise_valid` level that the controller uses to stop its voltage sweep and store the current DAC code. The block synchronises the input, debounces it, and counts rising edges over a fixed measurement window. At the end of each window it issues one registered verdict.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `comp_in`; legal range 2..4.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before the debounced level changes; legal range ≥1.
- `WINDOW_CYCLES`, 50000: measurement window length in clk cycles (1 ms at 50 MHz).
- `MIN_EDGES`, 4: debounced rising edges per window required to declare noise; legal range 1..255.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`; 0 = reset.
- `enable`  in  1  level. 1 = run measurement windows back-to-back.
- `comp_in`  in  1  raw asynchronous comparator output.
- `noise_valid`  out  1  registered verdict of the last completed window.
- `edge_count`  out  8  edge count of the last completed window, saturating at 255.
- `window_done`  out  1  one-cycle pulse when `noise_valid` and `edge_count` update.
- `busy`  out  1  high while a window is in progress.

## Operation
- State machine `IDLE` → `COUNT` → (`COUNT` | `IDLE`).
- **IDLE**
  - Window counter and running edge counter are held at 0.
  - Moves to `COUNT` on the cycle after `enable` is sampled 1.
- **COUNT**
  - Window counter increments 0..`WINDOW_CYCLES`-1.
  - Each debounced 0→1 transition increments the running edge counter, which saturates at 255.
- **End of window** (window counter = `WINDOW_CYCLES`-1):
  - `edge_count` ← running count, including any edge detected in that same cycle.
  - `noise_valid` ← (running count ≥ `MIN_EDGES`).
  - `window_done` pulses.
  - Running count and window counter clear.
  - Stays in `COUNT` if `enable`=1, otherwise goes to `IDLE`.
- **`enable` deasserted mid-window**
  - Window is aborted; go to `IDLE` next cycle.
  - `noise_valid` clears to 0; `edge_count` holds its last value.
  - No `window_done` pulse.
- **Debounce filter**
  - Debounced level changes only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing cycle restarts the stability counter.
  - The filter runs regardless of `enable`, so the first window starts from a settled level.
- Falling debounced edges are ignored.
- Reset has priority over every other condition, including an end-of-window cycle coinciding with reset.

## Timing
- Reset values:
  - `noise_valid`=0, `edge_count`=0, `window_done`=0, `busy`=0.
  - State `IDLE`; all counters 0.
  - Synchroniser flops and debounced level = 0.
- `comp_in` edge to debounced edge: `SYNC_STAGES` + `DEBOUNCE_CYCLES` cycles.
- Debounced edge to running count: +1 cycle.
- `enable` 0→1 to `busy`=1: 1 cycle. The first window then lasts exactly `WINDOW_CYCLES` cycles of `busy`=1.
- `window_done` and the new `noise_valid`/`edge_count` appear together, registered, in the cycle after window counter = `WINDOW_CYCLES`-1.
- Back-to-back windows have no dead cycle.
- `busy` stays 1 across window boundaries while `enable`=1.

## Configuration
- `NOISE_QUALIFIER_DEBOUNCE_EN` defined: debounce filter instantiated as described.
- Not defined:
  - Debounced level = last synchroniser stage.
  - `DEBOUNCE_CYCLES` is ignored.
  - Latency from `comp_in` edge to debounced edge is `SYNC_STAGES` cycles.
  - All other behaviour is identical.

## Structure
- Shared package `noise_qualifier_pkg`:
  - State enum (`IDLE`, `COUNT`).
  - `EDGE_CNT_W`=8 and the saturation constant 255.
  - Window counter width function `$clog2(WINDOW_CYCLES)`.
- Sub-module `debounce_filter`: synchroniser, stability counter, and debounced level output. Compiled in only under `NOISE_QUALIFIER_DEBOUNCE_EN`.

## Test plan
All scenarios use bench parameters `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `WINDOW_CYCLES`=100, `MIN_EDGES`=3.
- **Reset:** hold `reset`=0 for 5 cycles with `comp_in` toggling → all outputs 0, `busy`=0; release → outputs remain 0 while `enable`=0.
- **Noise detected:** `enable`=1; 5 clean pulses, each 10 cycles high / 10 cycles low, inside the window → `window_done` pulses once, `edge_count`=5, `noise_valid`=1.
- **Glitch rejection:** 3 pulses each 2 cycles wide plus 2 pulses each 10 cycles wide → `edge_count`=2, `noise_valid`=0. With the macro undefined, the same stimulus gives `edge_count`=5, `noise_valid`=1.
- **Abort mid-window:** drop `enable` at window cycle 50 after 4 edges → no `window_done`, `noise_valid`=0, `busy`=0 next cycle, `edge_count` unchanged.
- **Saturation and back-to-back windows:** `WINDOW_CYCLES`=4000, `comp_in` toggling every 6 cycles → `edge_count`=255 and `noise_valid`=1. Consecutive `window_done` pulses are exactly 4000 cycles apart, and `busy` stays 1 throughout.
